// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution stage and its pattern history table.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_GT     = 3'b010,
        COND_LE     = 3'b011,
        COND_LT     = 3'b100,
        COND_GE     = 3'b101,
        COND_GTU    = 3'b110,
        COND_ALWAYS = 3'b111
    } cond_e;

    localparam logic [1:0] PHT_SNT = 2'b00;
    localparam logic [1:0] PHT_WNT = 2'b01;
    localparam logic [1:0] PHT_WT  = 2'b10;
    localparam logic [1:0] PHT_ST  = 2'b11;

    localparam logic [1:0] PHT_RST = PHT_WNT;

endpackage

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters: one combinational lookup port and one
// update port. A lookup and an update to the same entry in one cycle see the old value.
module branch_pht
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_lookup_taken,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_pht [DEPTH];

    assign o_lookup_taken = r_pht[i_lookup_idx][1];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pht[i] <= PHT_RST;
            end
        end else if (i_upd_en) begin
            if (i_upd_taken && r_pht[i_upd_idx] != PHT_ST) begin
                r_pht[i_upd_idx] <= r_pht[i_upd_idx] + 2'd1;
            end else if (!i_upd_taken && r_pht[i_upd_idx] != PHT_SNT) begin
                r_pht[i_upd_idx] <= r_pht[i_upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: condition evaluation, target computation, mispredict detection,
// single-entry output register with valid/ready handshake, PHT training and statistics.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid=0
// ST_FULL  | result held in output register, out_valid=1
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int PHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cond_sel,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [PC_W-1:0]   pc,
    input  logic [15:0]       offset,
    input  logic              pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [PC_W-1:0]   out_target,
    output logic [PC_W-1:0]   out_redirect_pc,
    output logic              out_mispredict,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              lookup_taken,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_taken;
    logic [PC_W-1:0]  r_target;
    logic [PC_W-1:0]  r_redirect;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_accept;
    logic             w_taken;
    logic             w_mispredict;
    logic [PC_W-1:0]  w_pc_plus4;
    logic [PC_W-1:0]  w_off_ext;
    logic [PC_W-1:0]  w_target;

    always_comb begin
        w_taken = 1'b0;
        case (cond_e'(cond_sel))
            COND_EQ:     w_taken = (op_a == op_b);
            COND_NE:     w_taken = (op_a != op_b);
            COND_GT:     w_taken = ($signed(op_a) >  $signed(op_b));
            COND_LE:     w_taken = ($signed(op_a) <= $signed(op_b));
            COND_LT:     w_taken = ($signed(op_a) <  $signed(op_b));
            COND_GE:     w_taken = ($signed(op_a) >= $signed(op_b));
            COND_GTU:    w_taken = (op_a > op_b);
            COND_ALWAYS: w_taken = 1'b1;
            default:     w_taken = 1'b0;
        endcase
    end

    // Word offset, sign-extended and scaled to bytes; adder wraps silently.
    assign w_off_ext    = {{(PC_W-18){offset[15]}}, offset, 2'b00};
    assign w_pc_plus4   = pc + PC_W'(4);
    assign w_target     = w_pc_plus4 + w_off_ext;
    assign w_mispredict = (w_taken != pred_taken);

    // Ready is forced high while reset is held; the reset branch below still blocks capture.
    assign in_ready = !reset || (r_state == ST_EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_EMPTY;
            r_taken       <= 1'b0;
            r_target      <= '0;
            r_redirect    <= '0;
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (out_ready && !in_valid) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_accept) begin
                r_taken      <= w_taken;
                r_target     <= w_target;
                r_redirect   <= w_taken ? w_target : w_pc_plus4;
                r_mispredict <= w_mispredict;
                if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                if (w_mispredict && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid        = (r_state == ST_FULL);
    assign out_taken        = r_taken;
    assign out_target       = r_target;
    assign out_redirect_pc  = r_redirect;
    assign out_mispredict   = r_mispredict;
    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mispred_cnt;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                             pc[PC_W-1:IDX_W+2], pc[1:0]};

    branch_pht #(
        .DEPTH (PHT_DEPTH)
    ) u_pht (
        .i_clk          (clk),
        .i_reset_n      (reset),
        .i_lookup_idx   (lookup_pc[IDX_W+1:2]),
        .o_lookup_taken (lookup_taken),
        .i_upd_en       (w_accept),
        .i_upd_idx      (pc[IDX_W+1:2]),
        .i_upd_taken    (w_taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of hand-computed branch results plus
// reset, PHT saturation and backpressure sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cond_sel;
    logic [31:0] op_a, op_b, pc;
    logic [15:0] offset;
    logic        pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target, out_redirect_pc;
    logic        out_mispredict;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [15:0] branch_count, mispredict_count;

    int total = 0;
    int bad   = 0;
    int exp_bc = 0;
    int exp_mc = 0;

    typedef struct {
        logic [2:0]  cond;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [15:0] off;
        logic        pred;
        logic        e_taken;
        logic [31:0] e_target;
        logic [31:0] e_redirect;
        logic        e_mis;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cond_sel         (cond_sel),
        .op_a             (op_a),
        .op_b             (op_b),
        .pc               (pc),
        .offset           (offset),
        .pred_taken       (pred_taken),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_taken        (out_taken),
        .out_target       (out_target),
        .out_redirect_pc  (out_redirect_pc),
        .out_mispredict   (out_mispredict),
        .lookup_pc        (lookup_pc),
        .lookup_taken     (lookup_taken),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [15:0] o, input logic pr);
        cond_sel   = c;
        op_a       = a;
        op_b       = b;
        pc         = p;
        offset     = o;
        pred_taken = pr;
    endtask

    initial begin
        logic [31:0] held_target;
        logic        held_taken;
        int          bc_hold;

        vecs[0]  = '{3'b000, 32'd5,        32'd5,        32'h100,      16'h0004, 1'b0, 1'b1, 32'h114,      32'h114,      1'b1};
        vecs[1]  = '{3'b010, 32'hFFFFFFFF, 32'd1,        32'h200,      16'h0008, 1'b1, 1'b0, 32'h224,      32'h204,      1'b1};
        vecs[2]  = '{3'b110, 32'hFFFFFFFF, 32'd1,        32'h200,      16'h0008, 1'b1, 1'b1, 32'h224,      32'h224,      1'b0};
        vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h300,      16'hFFFF, 1'b0, 1'b1, 32'h300,      32'h300,      1'b1};
        vecs[4]  = '{3'b001, 32'd3,        32'd3,        32'h10,       16'h0001, 1'b0, 1'b0, 32'h18,       32'h14,       1'b0};
        vecs[5]  = '{3'b011, 32'h80000000, 32'h7FFFFFFF, 32'h20,       16'h0002, 1'b1, 1'b1, 32'h2C,       32'h2C,       1'b0};
        vecs[6]  = '{3'b101, 32'd1,        32'hFFFFFFFF, 32'h24,       16'h0000, 1'b0, 1'b1, 32'h28,       32'h28,       1'b1};
        vecs[7]  = '{3'b111, 32'd0,        32'd9,        32'hFFFFFFFC, 16'h0000, 1'b1, 1'b1, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{3'b111, 32'd0,        32'd0,        32'h00020000, 16'h8000, 1'b1, 1'b1, 32'h4,        32'h4,        1'b0};
        vecs[9]  = '{3'b000, 32'd5,        32'd6,        32'hFFFFFFFC, 16'h0000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{3'b110, 32'd1,        32'hFFFFFFFF, 32'h30,       16'h0010, 1'b1, 1'b0, 32'h74,       32'h34,       1'b1};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        lookup_pc = 32'h0;
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset branch_count", {16'b0, branch_count}, 32'd0);
        chk("reset mispredict_count", {16'b0, mispredict_count}, 32'd0);
        chk("reset lookup_taken", {31'b0, lookup_taken}, 32'd0);
        chk("reset out_target", out_target, 32'd0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].off, vecs[i].pred);
            in_valid = 1'b1;
            tick();
            exp_bc++;
            if (vecs[i].e_mis) exp_mc++;
            chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d out_taken", i), {31'b0, out_taken}, {31'b0, vecs[i].e_taken});
            chk($sformatf("vec%0d out_target", i), out_target, vecs[i].e_target);
            chk($sformatf("vec%0d out_redirect_pc", i), out_redirect_pc, vecs[i].e_redirect);
            chk($sformatf("vec%0d out_mispredict", i), {31'b0, out_mispredict}, {31'b0, vecs[i].e_mis});
            chk($sformatf("vec%0d branch_count", i), {16'b0, branch_count}, exp_bc);
            chk($sformatf("vec%0d mispredict_count", i), {16'b0, mispredict_count}, exp_mc);
        end

        // Reset mid-stream with a valid result held and an input still offered.
        lookup_pc = 32'h100;
        #1;
        chk("pre-reset lookup idx0", {31'b0, lookup_taken}, 32'd1);
        out_ready = 1'b0;
        reset     = 1'b0;
        #1;
        chk("in_ready during reset", {31'b0, in_ready}, 32'd1);
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        exp_bc = 0;
        exp_mc = 0;
        chk("mid reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid reset branch_count", {16'b0, branch_count}, 32'd0);
        chk("mid reset mispredict_count", {16'b0, mispredict_count}, 32'd0);
        chk("mid reset out_taken", {31'b0, out_taken}, 32'd0);
        chk("mid reset out_redirect_pc", out_redirect_pc, 32'd0);
        for (int k = 0; k < 16; k++) begin
            lookup_pc = 32'(k * 4);
            #1;
            chk($sformatf("mid reset lookup idx%0d", k), {31'b0, lookup_taken}, 32'd0);
        end

        // PHT saturation at pc 0x40.
        lookup_pc = 32'h40;
        drive(3'b111, 0, 0, 32'h40, 16'h0000, 1'b0);
        in_valid = 1'b1;
        #1;
        chk("pht read-before-write", {31'b0, lookup_taken}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            tick();
            exp_bc++;
            exp_mc++;
            chk($sformatf("pht taken%0d lookup", t), {31'b0, lookup_taken}, 32'd1);
        end
        drive(3'b000, 32'd1, 32'd2, 32'h40, 16'h0000, 1'b0);
        tick();
        exp_bc++;
        chk("pht nt1 lookup (11->10)", {31'b0, lookup_taken}, 32'd1);
        tick();
        exp_bc++;
        chk("pht nt2 lookup (10->01)", {31'b0, lookup_taken}, 32'd0);
        chk("pht branch_count", {16'b0, branch_count}, exp_bc);
        chk("pht mispredict_count", {16'b0, mispredict_count}, exp_mc);

        // Backpressure: new branch offered while the result is stalled.
        held_taken  = out_taken;
        held_target = out_target;
        bc_hold     = exp_bc;
        chk("bp held taken", {31'b0, held_taken}, 32'd0);
        chk("bp held target", held_target, 32'h44);
        drive(3'b001, 32'd1, 32'd2, 32'h80, 16'h0004, 1'b0);
        out_ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("bp%0d in_ready", s), {31'b0, in_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d out_valid", s), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d out_target", s), out_target, 32'h44);
            chk($sformatf("bp%0d out_taken", s), {31'b0, out_taken}, 32'd0);
            chk($sformatf("bp%0d branch_count", s), {16'b0, branch_count}, bc_hold);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        exp_bc++;
        exp_mc++;
        chk("bp new out_target", out_target, 32'h94);
        chk("bp new out_taken", {31'b0, out_taken}, 32'd1);
        chk("bp new branch_count", {16'b0, branch_count}, exp_bc);
        chk("bp new mispredict_count", {16'b0, mispredict_count}, exp_mc);
        tick();
        chk("bp drained out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp no duplicate branch_count", {16'b0, branch_count}, exp_bc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
